// File: rtl/muldiv_sched.sv
// muldiv_sched: multi-cycle scheduler and iterative datapath for the HI/LO
// multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU issues and
// MTHI/MTLO writes, holds the architectural HI/LO registers, stalls decode
// while a HI/LO access collides with an in-flight operation, and serves
// MFHI/MFLO read data.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      issue a mult/div this cycle
//   ALU2Op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   RHLWr      HI/LO direct write request
//   RHLSel_Wr  01 MTHI, 00 MTLO, 10 mult/div (ignored on direct path)
//   RHLSel_Rd  read select: 1 HI, 0 LO
//   RHL_visit  decode-stage instruction touches HI/LO
//   flush      kills the in-flight op and any same-cycle request
//   rs_data    operand A (dividend / multiplicand / MTHI-MTLO source)
//   rt_data    operand B (divisor / multiplier)
//   busy       operation in flight
//   stall      RHL_visit && busy
//   done       one-cycle pulse after HI/LO are written by an op
//   hi, lo     architectural HI/LO
//   rhl_rdata  RHLSel_Rd ? hi : lo
module muldiv_sched #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      ALU2Op,
    input  logic            RHLWr,
    input  logic [1:0]      RHLSel_Wr,
    input  logic            RHLSel_Rd,
    input  logic            RHL_visit,
    input  logic            flush,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] rhl_rdata
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            r_state, w_nextState;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo;
    logic [XLEN-1:0]   r_accHi, r_accLo;
    logic [XLEN-1:0]   r_operand;
    logic [XLEN-1:0]   r_rawA;
    logic              r_isDiv, r_negQ, r_negR, r_divZero, r_done;

    logic              w_startAcc, w_wrAcc;
    logic              w_negA, w_negB;
    logic [XLEN-1:0]   w_absA, w_absB;
    logic [XLEN:0]     w_mulSum;
    logic [XLEN:0]     w_remShift;
    logic [XLEN-1:0]   w_remSub;
    logic              w_geq;
    logic [2*XLEN-1:0] w_prod, w_prodFix;
    logic [XLEN-1:0]   w_quoFix, w_remFix;

    assign busy      = (r_state != IDLE);
    assign stall     = RHL_visit && busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign rhl_rdata = RHLSel_Rd ? r_hi : r_lo;

    assign w_startAcc = start && !busy && !flush;
    assign w_wrAcc    = RHLWr && !start && !busy && !flush;

    // Signed ops work on magnitudes; the signs are reapplied in FIX.
    assign w_negA = ALU2Op[0] & rs_data[XLEN-1];
    assign w_negB = ALU2Op[0] & rt_data[XLEN-1];
    assign w_absA = w_negA ? -rs_data : rs_data;
    assign w_absB = w_negB ? -rt_data : rt_data;

    // Multiply step: accumulator {carry, accHi, accLo}, shifted right once
    // per cycle so the multiplier bits drain out of accLo[0].
    assign w_mulSum = r_accLo[0] ? ({1'b0, r_accHi} + {1'b0, r_operand})
                                 : {1'b0, r_accHi};

    // Restoring divide step. The shifted remainder needs one extra bit for
    // the compare; after a subtract it always fits back into XLEN bits.
    assign w_remShift = {r_accHi, r_accLo[XLEN-1]};
    assign w_geq      = (w_remShift >= {1'b0, r_operand});
    assign w_remSub   = w_remShift[XLEN-1:0] - r_operand;

    assign w_prod    = {r_accHi, r_accLo};
    assign w_prodFix = r_negQ ? -w_prod : w_prod;
    assign w_quoFix  = r_negQ ? -r_accLo : r_accLo;
    assign w_remFix  = r_negR ? -r_accHi : r_accHi;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_nextState;
    end

    // Next-state logic; flush drops any in-flight op back to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_startAcc) w_nextState = CALC;
            CALC: begin
                if (flush)                             w_nextState = IDLE;
                else if (r_cnt == CW'(XLEN - 1))       w_nextState = FIX;
            end
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, writeback, and direct writes.
    // accHi/accLo double as {acc_hi, multiplier} or {remainder, quotient}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_operand <= '0;
            r_rawA    <= '0;
            r_isDiv   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_divZero <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_startAcc) begin
                        r_cnt     <= '0;
                        r_isDiv   <= ALU2Op[1];
                        r_negQ    <= w_negA ^ w_negB;
                        r_negR    <= w_negA;
                        r_divZero <= ALU2Op[1] && (rt_data == '0);
                        r_rawA    <= rs_data;
                        r_accHi   <= '0;
                        if (ALU2Op[1]) begin
                            r_accLo   <= w_absA;
                            r_operand <= w_absB;
                        end else begin
                            r_accLo   <= w_absB;
                            r_operand <= w_absA;
                        end
                    end else if (w_wrAcc) begin
                        if (RHLSel_Wr == 2'b01)      r_hi <= rs_data;
                        else if (RHLSel_Wr == 2'b00) r_lo <= rs_data;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_isDiv) begin
                            r_accHi <= w_geq ? w_remSub : w_remShift[XLEN-1:0];
                            r_accLo <= {r_accLo[XLEN-2:0], w_geq};
                        end else begin
                            r_accHi <= w_mulSum[XLEN:1];
                            r_accLo <= {w_mulSum[0], r_accLo[XLEN-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (!r_isDiv) begin
                            {r_hi, r_lo} <= w_prodFix;
                        end else if (r_divZero) begin
                            r_lo <= '1;
                            r_hi <= r_rawA;
                        end else begin
                            r_lo <= w_quoFix;
                            r_hi <= w_remFix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle scheduler and iterative datapath for the HI/LO multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU issues and MTHI/MTLO writes from the decode-stage control signals (`start`, `ALU2Op`, `RHLWr`, `RHLSel_Wr`, `RHLSel_Rd`, `RHL_visit`). It holds the HI/LO registers and raises a pipeline stall while any HI/LO access collides with an in-flight operation. It sits beside the EXE stage and serves MFHI/MFLO read data to the writeback mux.

## Interface
Parameters:
- `XLEN`, default 32. Operand width. Only 32 is supported; the 32-iteration count is tied to it.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue a mult/div this cycle.
- `ALU2Op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `RHLWr`  in  1  HI/LO write request.
- `RHLSel_Wr`  in  2  write select: 01 MTHI, 00 MTLO, 10 mult/div (ignored on the direct-write path).
- `RHLSel_Rd`  in  1  read select: 1 HI, 0 LO.
- `RHL_visit`  in  1  the decode-stage instruction touches HI/LO.
- `flush`  in  1  exception/eret; kills the in-flight op and any same-cycle request.
- `rs_data`  in  32  operand A (dividend/multiplicand; MTHI/MTLO source).
- `rt_data`  in  32  operand B (divisor/multiplier).
- `busy`  out  1  operation in flight (`state` != IDLE).
- `stall`  out  1  `RHL_visit && busy`.
- `done`  out  1  registered one-cycle pulse after HI/LO are written by an op.
- `hi`, `lo`  out  32  architectural HI/LO.
- `rhl_rdata`  out  32  `RHLSel_Rd ? hi : lo`, combinational.

## Operation
- States:
  - IDLE: accept a start or a direct write.
  - CALC: 32 iterations.
  - FIX: sign correction and HI/LO writeback.
- Accept rules:
  - A start is accepted when `start && !busy && !flush`. Operands are latched, `cnt` is set to 0, and the state goes to CALC.
  - A direct write is accepted when `RHLWr && !start && !busy && !flush` and `RHLSel_Wr` is 01 (HI ← `rs_data`) or 00 (LO ← `rs_data`).
- Signed ops (MULT, DIV):
  - Magnitudes of the operands are latched.
  - `neg_q` = sign(A) XOR sign(B).
  - `neg_r` = sign(A).
- Multiply: radix-2 shift-add on a 65-bit accumulator {carry, acc_hi, acc_lo = multiplier}. Each CALC cycle: if `acc_lo[0]`, add the multiplicand into `acc_hi` with a 33-bit carry, then shift the whole accumulator right by 1.
- Divide: restoring division. Each CALC cycle:
  - shift {rem, quo} left by 1, bringing in the next dividend bit;
  - if rem ≥ divisor, subtract the divisor and set `quo[0]`.
- CALC → FIX when `cnt` == 31; otherwise `cnt`++.
- FIX, multiply: {HI, LO} ← product, two's-complement negated as 64 bits if `neg_q`.
- FIX, divide: LO ← quo (negated if `neg_q`); HI ← rem (negated if `neg_r`).
- FIX always → IDLE, with `done` set for the following cycle.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = `rs_data` as latched, with no sign fix.
- 0x80000000 / −1 (DIV): LO = 0x80000000, HI = 0 (natural wrap).
- `flush` while busy: next state is IDLE, HI/LO unchanged, no `done`. A same-cycle `start` or `RHLWr` is ignored.
- MFHI/MFLO/MTHI/MTLO or a new mult/div while busy: `stall` holds decode until the cycle after FIX; the bypassed value is then already in HI/LO.

## Timing
- Reset (async, `rst`=0): state IDLE, `cnt`=0, `hi`=`lo`=0, `busy`=0, `done`=0, `stall`=0, `rhl_rdata`=0.
- Start accepted at edge E0:
  - `busy` is high from E0 through E33.
  - E1–E32 are the CALC iterations.
  - E33 is the FIX writeback; HI/LO show the new values after E33.
  - `done`=1 for exactly the cycle after E33.
  - Issue-to-result latency is 33 cycles.
- Back-to-back ops: the earliest next accept is E33+1, i.e. when `busy` has fallen.
- Direct writes: a 1-cycle write, visible on `hi`/`lo` after the edge.
- `stall` is combinational and is never asserted when `busy`=0.
- `rst` asserted mid-op: immediate abort to the reset values.

## Test plan
- MULTU with A=B=0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; `done` pulses once; `busy` is high for 33 cycles.
- MULT with A=0xFFFFFFFD (−3), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV with A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with A=0x12345678, B=0 → LO=0xFFFFFFFF, HI=0x12345678. DIV with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- With HI preloaded to 0x55 via MTHI, issue DIVU 100/7, then assert `flush` at cycle 10 → `busy` falls the next cycle, HI=0x55, no `done`.
- DIVU 100/7 followed by MFHI (`RHL_visit`=1, `RHLSel_Rd`=1) during busy → `stall` is high until `busy` falls; then `rhl_rdata`=2, and LO=14.
- Start a MULT, then drive `rst`=0 at cycle 5 → all outputs zero immediately; after release, an MTLO of 0xA5 gives LO=0xA5 one cycle later.
